mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 157 +++++++++++++++
 tb/tb_mult_div_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// MIPS-style HI/LO multiply/divide unit; divider built only with `MDU_DIV_EN defined.
// Latency: MULT/MULTU busy MULT_CYCLES, DIV/DIVU busy DIV_CYCLES, MTHI/MTLO write next edge.
// Backpressure: none internal; starts are ignored while busy, upstream must stall on busy.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,  // legal 1..15
    parameter int DIV_CYCLES  = 10  // legal 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [2:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        start_mul;
    logic        start_div;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        start_mul = start && ((mdop == OP_MULT) || (mdop == OP_MULTU));
        start_div = 1'b0;
`ifdef MDU_DIV_EN
        start_div = start && ((mdop == OP_DIV) || (mdop == OP_DIVU));
`endif
    end

    // Sign-extending to 64 bits lets one unsigned multiplier serve both MULT and MULTU.
    always_comb begin
        if (op_code == OP_MULT) begin
            a_ext = {{32{op_a[31]}}, op_a};
            b_ext = {{32{op_b[31]}}, op_b};
        end else begin
            a_ext = {32'd0, op_a};
            b_ext = {32'd0, op_b};
        end
        prod = a_ext * b_ext;
    end

`ifdef MDU_DIV_EN
    logic        div_sgn;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    // Divide magnitudes unsigned, then restore signs; 0x80000000 / -1 wraps to 0x80000000 r 0.
    always_comb begin
        div_sgn = (op_code == OP_DIV);
        neg_a   = div_sgn & op_a[31];
        neg_b   = div_sgn & op_b[31];
        mag_a   = neg_a ? (~op_a + 32'd1) : op_a;
        mag_b   = neg_b ? (~op_b + 32'd1) : op_b;
        q_mag   = 32'd0;
        r_mag   = 32'd0;
        if (mag_b != 32'd0) begin
            q_mag = mag_a / mag_b;
            r_mag = mag_a % mag_b;
        end
        quo = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
        rem = neg_a ? (~r_mag + 32'd1) : r_mag;
    end
`endif

    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_code)
            OP_MULT, OP_MULTU: begin
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
                if (op_b != 32'd0) begin
                    res_hi = rem;
                    res_lo = quo;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            op_code <= 3'd0;
            op_a    <= 32'd0;
            op_b    <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_mul || start_div) begin
                        op_code <= mdop;
                        op_a    <= a;
                        op_b    <= b;
                        cnt     <= start_div ? DIV_LOAD : MULT_LOAD;
                        state   <= RUN;
                    end else if (start && (mdop == OP_MTHI)) begin
                        hi_q <= a;
                    end else if (start && (mdop == OP_MTLO)) begin
                        lo_q <= a;
                    end
                end
                default: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        hi_q  <= res_hi;
                        lo_q  <= res_lo;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit; divide expectations follow `MDU_DIV_EN.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mdop  (mdop),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one start cycle; returns just after the start edge.
    task automatic do_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        mdop  = op;
        a     = av;
        b     = bv;
        step();
        start = 1'b0;
        mdop  = 3'b111;
        a     = 32'd0;
        b     = 32'd0;
    endtask

    task automatic wait_idle(input string tag, input int exp);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            step();
        end
        chk(tag, 64'(n), 64'(exp));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        mdop  = 3'b100;
        a     = 32'hDEAD_BEEF;
        b     = 32'd0;
        repeat (2) step();
        reset = 1'b0;
        start = 1'b0;
        mdop  = 3'b111;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);

        do_op(3'b000, 32'hFFFF_FFFE, 32'd3);
        chk("mult_busy_c1", 64'(busy), 64'd1);
        chk("mult_hold_hi", 64'(hi), 64'd0);
        chk("mult_hold_lo", 64'(lo), 64'd0);
        wait_idle("mult_cycles", 5);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFFA);

        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle("multu_cycles", 5);
        chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo), 64'h0000_0001);

        do_op(3'b000, 32'd7, 32'd6);
        do_op(3'b101, 32'h1234, 32'd0);
        chk("mtlo_busy_ignored", 64'(lo), 64'h1);
        chk("mtlo_busy_still", 64'(busy), 64'd1);
        wait_idle("mult_rest_cycles", 4);
        chk("mult76_hi", 64'(hi), 64'd0);
        chk("mult76_lo", 64'(lo), 64'd42);

        do_op(3'b101, 32'h1234, 32'd0);
        chk("mtlo_lo", 64'(lo), 64'h1234);
        chk("mtlo_busy", 64'(busy), 64'd0);
        step();
        chk("mtlo_busy_after", 64'(busy), 64'd0);

        do_op(3'b100, 32'h11, 32'd0);
        do_op(3'b101, 32'h22, 32'd0);
        chk("mthi_hi", 64'(hi), 64'h11);
        chk("mthi_busy", 64'(busy), 64'd0);

`ifdef MDU_DIV_EN
        do_op(3'b011, 32'd5, 32'd0);
        wait_idle("divu0_cycles", 10);
        chk("divu0_hi", 64'(hi), 64'h11);
        chk("divu0_lo", 64'(lo), 64'h22);

        do_op(3'b010, 32'hFFFF_FFF9, 32'd2);
        wait_idle("div_cycles", 10);
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);

        do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("divovf_cycles", 10);
        chk("divovf_lo", 64'(lo), 64'h8000_0000);
        chk("divovf_hi", 64'(hi), 64'd0);

        do_op(3'b011, 32'd100, 32'd7);
        wait_idle("divu_cycles", 10);
        chk("divu_lo", 64'(lo), 64'd14);
        chk("divu_hi", 64'(hi), 64'd2);
`else
        do_op(3'b011, 32'd5, 32'd0);
        chk("divu0_nobusy", 64'(busy), 64'd0);
        chk("divu0_hi", 64'(hi), 64'h11);
        chk("divu0_lo", 64'(lo), 64'h22);

        do_op(3'b010, 32'hFFFF_FFF9, 32'd2);
        chk("div_nobusy", 64'(busy), 64'd0);
        step();
        chk("div_hi", 64'(hi), 64'h11);
        chk("div_lo", 64'(lo), 64'h22);
`endif

        do_op(3'b110, 32'hAAAA_5555, 32'd9);
        chk("nop_busy", 64'(busy), 64'd0);
        do_op(3'b111, 32'h5555_AAAA, 32'd9);
        chk("nop7_busy", 64'(busy), 64'd0);
`ifdef MDU_DIV_EN
        chk("nop_hi", 64'(hi), 64'd2);
        chk("nop_lo", 64'(lo), 64'd14);
`else
        chk("nop_hi", 64'(hi), 64'h11);
        chk("nop_lo", 64'(lo), 64'h22);
`endif

        do_op(3'b000, 32'd3, 32'd4);
        step();
        step();
        chk("abort_busy_c3", 64'(busy), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        repeat (8) step();
        chk("abort_late_busy", 64'(busy), 64'd0);
        chk("abort_late_hi", 64'(hi), 64'd0);
        chk("abort_late_lo", 64'(lo), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
